crt_loader: RTL

- Byte-stream parser/sequencer that turns a downloaded .CRT image into the cartridge mapper's configuration.
- Validates the file header and extracts hardware type and EXROM/GAME.
- Walks the CHIP packets, copies each image into SDRAM at 8K-aligned slots, and issues one bank-table write per packet.
- Sits between the download channel (ioctl) and the cartridge mapper and SDRAM write port.

---
 rtl/crt_loader.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/crt_loader.sv
// Parses a streamed .CRT image: checks the header, copies CHIP images into SDRAM
// at 8K-aligned slots, and issues one bank-table write per CHIP packet.
module crt_loader #(
  parameter logic [23:0] BASE_ADDR = 24'h100000,
  parameter logic [23:0] MAX_SIZE  = 24'h100000
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic [15:0] cart_id,
  output logic [7:0]  cart_exrom,
  output logic [7:0]  cart_game,
  output logic [15:0] cart_bank_laddr,
  output logic [15:0] cart_bank_size,
  output logic [15:0] cart_bank_num,
  output logic [7:0]  cart_bank_type,
  output logic [23:0] cart_bank_raddr,
  output logic        cart_bank_wr,
  output logic        cart_loading,
  output logic        cart_attached,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic        crt_error
);
  typedef enum logic [2:0] {
    S_IDLE, S_SIG, S_HDR, S_SKIP_HDR, S_CHIP_HDR, S_DATA, S_SKIP_PAD, S_ERR
  } state_t;

  localparam logic [127:0] C_SIG   = "C64 CARTRIDGE   ";
  localparam logic [31:0]  C_CHIP  = "CHIP";
  localparam logic [24:0]  C_LIMIT = {1'b0, BASE_ADDR} + {1'b0, MAX_SIZE};

  state_t      r_state, w_nstate;
  logic [31:0] r_cnt, w_ncnt;
  logic        r_dl_d;
  logic [31:0] r_hlen, r_plen;
  logic [23:0] r_ptr;
  logic [15:0] r_chips;
  logic [15:0] r_cart_id, r_laddr, r_size, r_num;
  logic [7:0]  r_exrom, r_game, r_type, r_mem_data;
  logic [23:0] r_raddr, r_mem_addr;
  logic        r_bank_wr, r_loading, r_attached, r_mem_wr, r_err;

  logic        w_start, w_fall, w_bank_wr, w_mem_wr, w_ptr_adv, w_end_ok;
  logic [15:0] w_size, w_chips_nxt;
  logic [7:0]  w_sig_ch, w_chip_ch;
  logic [31:0] w_pkt_min, w_pkt_cur;
  logic [24:0] w_end_addr;
  logic [23:0] w_round;

  assign w_start     = ioctl_download & ~r_dl_d;
  assign w_fall      = ~ioctl_download & r_dl_d;
  assign w_sig_ch    = C_SIG[{~r_cnt[3:0], 3'b000} +: 8];
  assign w_chip_ch   = C_CHIP[{~r_cnt[1:0], 3'b000} +: 8];
  // Size as it will be once CHIP header byte 15 lands
  assign w_size      = {r_size[7:0], ioctl_data};
  assign w_pkt_min   = 32'd16 + {16'd0, w_size};
  assign w_pkt_cur   = 32'd16 + {16'd0, r_size};
  assign w_end_addr  = {1'b0, r_ptr} + {9'd0, w_size};
  assign w_round     = ({8'd0, r_size} + 24'h001FFF) & 24'hFFE000;
  assign w_chips_nxt = r_chips + {15'd0, w_bank_wr};
  assign w_end_ok    = (w_nstate == S_CHIP_HDR) && (w_ncnt == 32'd0) && !r_err &&
                       (w_chips_nxt != 16'd0);

  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_bank_wr = 1'b0;
    w_mem_wr  = 1'b0;
    w_ptr_adv = 1'b0;
    if (ioctl_wr) begin
      w_ncnt = r_cnt + 32'd1;
      case (r_state)
        S_SIG: begin
          if (ioctl_data != w_sig_ch) w_nstate = S_ERR;
          else if (r_cnt == 32'd15) w_nstate = S_HDR;
        end
        S_HDR: begin
          if (r_cnt == 32'h13 && {r_hlen[23:0], ioctl_data} < 32'h40) begin
            w_nstate = S_ERR;
          end else if (r_cnt == 32'h3F) begin
            if (r_hlen > 32'h40) begin
              w_nstate = S_SKIP_HDR;
            end else begin
              w_nstate = S_CHIP_HDR;
              w_ncnt   = 32'd0;
            end
          end
        end
        S_SKIP_HDR: begin
          if (r_cnt + 32'd1 == r_hlen) begin
            w_nstate = S_CHIP_HDR;
            w_ncnt   = 32'd0;
          end
        end
        S_CHIP_HDR: begin
          if (r_cnt < 32'd4 && ioctl_data != w_chip_ch) begin
            w_nstate = S_ERR;
          end else if (r_cnt == 32'd15) begin
            if (r_plen < w_pkt_min || w_end_addr > C_LIMIT) begin
              w_nstate = S_ERR;
            end else begin
              w_bank_wr = 1'b1;
              if (w_size != 16'd0) begin
                w_nstate = S_DATA;
                w_ncnt   = 32'd0;
              end else if (r_plen > 32'd16) begin
                w_nstate = S_SKIP_PAD;
                w_ncnt   = 32'd16;
              end else begin
                w_ncnt   = 32'd0;
              end
            end
          end
        end
        S_DATA: begin
          w_mem_wr = 1'b1;
          if (r_cnt == {16'd0, r_size} - 32'd1) begin
            w_ptr_adv = 1'b1;
            if (r_plen > w_pkt_cur) begin
              w_nstate = S_SKIP_PAD;
              w_ncnt   = w_pkt_cur;
            end else begin
              w_nstate = S_CHIP_HDR;
              w_ncnt   = 32'd0;
            end
          end
        end
        S_SKIP_PAD: begin
          if (r_cnt + 32'd1 == r_plen) begin
            w_nstate = S_CHIP_HDR;
            w_ncnt   = 32'd0;
          end
        end
        default: w_ncnt = r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (!reset) begin
      r_state <= S_IDLE;      r_cnt <= '0;        r_hlen <= '0;     r_plen <= '0;
      r_ptr <= BASE_ADDR;     r_chips <= '0;      r_cart_id <= '0;  r_laddr <= '0;
      r_size <= '0;           r_num <= '0;        r_exrom <= '0;    r_game <= '0;
      r_type <= '0;           r_mem_data <= '0;   r_raddr <= '0;    r_mem_addr <= '0;
      r_bank_wr <= 1'b0;      r_loading <= 1'b0;  r_attached <= 1'b0;
      r_mem_wr <= 1'b0;       r_err <= 1'b0;
      // Track the live level so a download already in flight is not seen as a new start
      r_dl_d <= ioctl_download;
    end else begin
      r_dl_d    <= ioctl_download;
      r_bank_wr <= 1'b0;
      r_mem_wr  <= 1'b0;
      if (w_start) begin
        r_state <= S_SIG;  r_cnt <= '0;  r_ptr <= BASE_ADDR;  r_chips <= '0;
        r_err <= 1'b0;     r_attached <= 1'b0;  r_loading <= 1'b1;
      end else begin
        if (ioctl_wr && r_state == S_HDR) begin
          if (r_cnt <= 32'h13) r_hlen <= {r_hlen[23:0], ioctl_data};
          if (r_cnt == 32'h16 || r_cnt == 32'h17) r_cart_id <= {r_cart_id[7:0], ioctl_data};
          if (r_cnt == 32'h18) r_exrom <= ioctl_data;
          if (r_cnt == 32'h19) r_game <= ioctl_data;
        end
        if (ioctl_wr && r_state == S_CHIP_HDR) begin
          case (r_cnt[3:0])
            4'd4, 4'd5, 4'd6, 4'd7: r_plen  <= {r_plen[23:0], ioctl_data};
            4'd8, 4'd9:             r_type  <= ioctl_data;
            4'd10, 4'd11:           r_num   <= {r_num[7:0], ioctl_data};
            4'd12, 4'd13:           r_laddr <= {r_laddr[7:0], ioctl_data};
            4'd14, 4'd15:           r_size  <= {r_size[7:0], ioctl_data};
            default: ;
          endcase
        end
        if (w_bank_wr) begin
          r_bank_wr <= 1'b1;
          r_raddr   <= r_ptr;
          r_chips   <= w_chips_nxt;
        end
        if (w_mem_wr) begin
          r_mem_wr   <= 1'b1;
          r_mem_addr <= r_ptr + r_cnt[23:0];
          r_mem_data <= ioctl_data;
        end
        if (w_ptr_adv) r_ptr <= r_ptr + w_round;
        if (w_nstate == S_ERR) r_err <= 1'b1;
        // A byte arriving with the falling edge is folded in before the end check
        if (w_fall && r_state != S_IDLE) begin
          r_state   <= S_IDLE;
          r_cnt     <= w_ncnt;
          r_loading <= 1'b0;
          if (w_end_ok) r_attached <= 1'b1;
          else          r_err      <= 1'b1;
        end else begin
          r_state <= w_nstate;
          r_cnt   <= w_ncnt;
        end
      end
    end
  end

  assign cart_id         = r_cart_id;
  assign cart_exrom      = r_exrom;
  assign cart_game       = r_game;
  assign cart_bank_laddr = r_laddr;
  assign cart_bank_size  = r_size;
  assign cart_bank_num   = r_num;
  assign cart_bank_type  = r_type;
  assign cart_bank_raddr = r_raddr;
  assign cart_bank_wr    = r_bank_wr;
  assign cart_loading    = r_loading;
  assign cart_attached   = r_attached;
  assign mem_addr        = r_mem_addr;
  assign mem_data        = r_mem_data;
  assign mem_wr          = r_mem_wr;
  assign crt_error       = r_err;
endmodule
